// File: rtl/axi2apb_rw_sched.sv
// Round-robin read/write scheduler driving one APB transfer at a time (IDLE->SETUP->ACCESS->RESP).
// Zero-wait latency: handshake N, rsp_valid N+3; a stalled rsp_ready holds RESP and blocks new requests.
module axi2apb_rw_sched #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_req_ready,
  input  logic                  wr_req_valid,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [31:0]           wr_req_data,
  output logic                  wr_req_ready,
  output logic                  rsp_valid,
  output logic                  rsp_read,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [31:0]           pwdata,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  last_wr_q, last_wr_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  rsp_read_q, rsp_read_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  gnt_rd, gnt_wr;

  // On a tie the type not granted last wins; last_wr_q resets to 1 so read wins first.
  assign gnt_rd = rd_req_valid && (!wr_req_valid || last_wr_q);
  assign gnt_wr = wr_req_valid && !gnt_rd;

  always_comb begin
    state_d      = state_q;
    last_wr_d    = last_wr_q;
    wait_cnt_d   = wait_cnt_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    rsp_read_d   = rsp_read_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    rd_req_ready = 1'b0;
    wr_req_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        // State sits at IDLE while rstn is low, so gate the readies explicitly.
        rd_req_ready = gnt_rd && rstn;
        wr_req_ready = gnt_wr && rstn;
        if (gnt_rd) begin
          paddr_d   = rd_req_addr;
          pwrite_d  = 1'b0;
          last_wr_d = 1'b0;
          state_d   = S_SETUP;
        end else if (gnt_wr) begin
          paddr_d   = wr_req_addr;
          pwdata_d  = wr_req_data;
          pwrite_d  = 1'b1;
          last_wr_d = 1'b1;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        wait_cnt_d = '0;
        state_d    = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          rsp_read_d = !pwrite_q;
          rsp_err_d  = pslverr;
          rsp_data_d = (pwrite_q || pslverr) ? 32'h0 : prdata;
          state_d    = S_RESP;
        end else if (TIMEOUT_CYCLES != 0 && wait_cnt_q == CW'(TO_LAST)) begin
          rsp_read_d = !pwrite_q;
          rsp_err_d  = 1'b1;
          rsp_data_d = 32'h0;
          state_d    = S_RESP;
        end else if (wait_cnt_q != {CW{1'b1}}) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      last_wr_q  <= 1'b1;
      wait_cnt_q <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      rsp_read_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      wait_cnt_q <= wait_cnt_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      rsp_read_q <= rsp_read_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable   = (state_q == S_ACCESS);
  assign rsp_valid = (state_q == S_RESP);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_read  = rsp_read_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/axi2apb_rw_sched.md
# axi2apb_rw_sched

Read/write scheduler and APB master sequencer for the AXI-to-APB bridge. It takes decoded single-beat read and write requests, arbitrates between them round-robin, and drives one APB transfer at a time through SETUP and ACCESS phases. It enforces a wait-state timeout and returns one response per transfer to the AXI-side response logic.

## Interface
- ADDR_WIDTH, 12, APB address width (4KB slave window)
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low; 0 disables the timeout
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- rd_req_valid  in  1  read request pending
- rd_req_addr  in  ADDR_WIDTH  read address
- rd_req_ready  out  1  read request accepted this cycle
- wr_req_valid  in  1  write request pending
- wr_req_addr  in  ADDR_WIDTH  write address
- wr_req_data  in  32  write data
- wr_req_ready  out  1  write request accepted this cycle
- rsp_valid  out  1  response available
- rsp_read  out  1  response belongs to a read
- rsp_data  out  32  read data; 0 for writes and for errors
- rsp_err  out  1  pslverr or timeout
- rsp_ready  in  1  response consumed
- psel  out  1  APB select (slave decode is downstream)
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data (already muxed)
- pready  in  1  APB ready (already muxed)
- pslverr  in  1  APB error (already muxed)

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Grant = read if only rd_req_valid; write if only wr_req_valid.
  - If both are valid, grant the type not granted last. The last-grant flag resets to "write", so read wins the first tie.
  - The granted ready is asserted combinationally in IDLE only. Both readies are 0 in every other state.
  - On handshake: latch addr, data (write only) and direction into paddr/pwdata/pwrite, update the last-grant flag, go to SETUP.
- SETUP: psel=1, penable=0; unconditionally go to ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - pready=1: capture rsp_data = pwrite ? 0 : prdata, rsp_err = pslverr, rsp_read = !pwrite, go to RESP.
  - pready=0: increment the wait counter, which is cleared on ACCESS entry.
  - If TIMEOUT_CYCLES≠0 and this is the TIMEOUT_CYCLES-th ACCESS cycle with pready=0: rsp_err=1, rsp_data=0, go to RESP (abort).
  - pready=1 on that same cycle wins; it is a normal completion.
- RESP:
  - psel=penable=0, rsp_valid=1.
  - rsp_data, rsp_err and rsp_read stay stable until rsp_ready; then go to IDLE.
- paddr, pwdata and pwrite are registers. They hold their values outside transfers and change only on a request handshake.
- Wait counter width is $clog2(TIMEOUT_CYCLES+1), min 1; it never wraps.
- Requesters must hold valid/addr/data until ready. The block does not queue requests.

## Timing
- Reset (async assert): state IDLE, last-grant = write, counter 0. All outputs 0: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_read, rsp_data, rsp_err; readies 0 while rstn low.
- Reset mid-transfer aborts immediately. No response is produced; psel drops in the same cycle rstn falls.
- Latency with zero wait states:
  - handshake in cycle N
  - SETUP in N+1
  - ACCESS in N+2 (pready=1)
  - rsp_valid in N+3
- With rsp_ready=1 in N+3: IDLE in N+4, next handshake possible in N+4. Peak rate is 1 transfer per 4 cycles.
- Each pready=0 cycle in ACCESS adds one cycle.
- Timeout case: ACCESS lasts exactly TIMEOUT_CYCLES cycles, and rsp_valid rises the cycle after.
- Stalled rsp_ready holds RESP indefinitely. No new request is accepted and psel stays 0.
- A request arriving while not in IDLE waits; it is accepted on the first IDLE cycle.

## Test plan
- Single read, addr 0x010, prdata=0xDEADBEEF, pready=1 in first ACCESS cycle -> psel in N+1..N+2, penable in N+2 only, rsp_valid N+3 with rsp_data=0xDEADBEEF, rsp_read=1, rsp_err=0.
- Single write, addr 0xFFC, data 0x12345678, pready low 3 cycles -> pwrite=1 and pwdata stable across SETUP and ACCESS, ACCESS lasts 4 cycles, rsp_data=0, rsp_err=0.
- Read and write both valid continuously from reset, 4 transfers -> grant order R,W,R,W; each request is accepted exactly once.
- pready held low, TIMEOUT_CYCLES=16 -> ACCESS lasts exactly 16 cycles, rsp_err=1, rsp_data=0; repeat with pready=1 on the 16th cycle -> normal completion, rsp_err=0.
- pslverr=1 with pready on a read, rsp_ready held low 5 cycles -> rsp_err=1, response stable 5 cycles, no readies asserted, psel=0 throughout.
- rstn pulsed low during ACCESS -> all outputs 0 immediately, no rsp_valid. The next tied request after reset is granted to read.
